cpu_control_fsm: RTL and testbench

//  Multi-cycle sequencer for the CPU core: fetches from instruction memory into
//  the instruction register (instr), pulses the decoder enable, then steps

---
 rtl/cpu_control_fsm_if.sv | 20 ++
 rtl/cpu_control_fsm.sv | 186 ++++++++++++++++++
 tb/tb_cpu_control_fsm.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_control_fsm_if.sv
// Instruction/data memory handshakes between the control sequencer and memories.
interface cpu_control_fsm_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        dmem_read;
    logic        dmem_write;
    logic        dmem_ack;

    modport master (
        output imem_req, imem_addr, dmem_read, dmem_write,
        input  imem_ack, imem_rdata, dmem_ack
    );

    modport slave (
        input  imem_req, imem_addr, dmem_read, dmem_write,
        output imem_ack, imem_rdata, dmem_ack
    );
endinterface

// File: rtl/cpu_control_fsm.sv
// Multi-cycle fetch/decode/execute/memory/writeback sequencer with PC and timeout.
// Optional condition-code evaluation is enabled by defining COND_EXEC_EN.
module cpu_control_fsm #(
    parameter logic [31:0]          RESET_PC    = 32'h0000_0000,
    parameter int                   TIMEOUT_W   = 8,
    parameter logic [TIMEOUT_W-1:0] MEM_TIMEOUT = 8'd255
) (
    input  logic                     clk,
    input  logic                     rst,
    cpu_control_fsm_if.master        mem,
    output logic [31:0]              instr,
    output logic                     dec_enable,
    output logic                     alu_enable,
    input  logic [3:0]               flags_nzcv,
    output logic                     rf_we,
    output logic [31:0]              pc,
    output logic                     fault,
    output logic                     busy
);

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXECUTE,
        S_MEMORY,
        S_WRITEBACK
    } state_t;

    state_t               state, state_d;
    logic [31:0]          pc_d, instr_d;
    logic                 fault_d;
    logic [TIMEOUT_W-1:0] cnt, cnt_d;

    logic [2:0]  cls;
    logic        is_dp, is_ls, is_br;
    logic        is_load, is_cmp;
    logic        cond_ok;
    logic        waiting, timeout;
    logic [31:0] br_off;

    assign cls     = instr[27:25];
    assign is_dp   = (cls[2:1] == 2'b00);
    assign is_ls   = (cls[2:1] == 2'b01);
    assign is_br   = (cls == 3'b101);
    assign is_load = instr[20];
    assign is_cmp  = (instr[24:23] == 2'b10);
    assign br_off  = {{6{instr[23]}}, instr[23:0], 2'b00};

    // The timeout cycle itself drops the request and ignores any late ack.
    assign waiting = (state == S_FETCH) || (state == S_MEMORY);
    assign timeout = waiting && (cnt == MEM_TIMEOUT);

`ifdef COND_EXEC_EN
    logic n_f, z_f, c_f, v_f;
    logic unused_bits;

    assign {n_f, z_f, c_f, v_f} = flags_nzcv;
    assign unused_bits = ^instr[22:21];

    always_comb begin
        cond_ok = 1'b0;
        unique case (instr[31:28])
            4'b0000: cond_ok = z_f;
            4'b0001: cond_ok = !z_f;
            4'b0010: cond_ok = c_f;
            4'b0011: cond_ok = !c_f;
            4'b0100: cond_ok = n_f;
            4'b0101: cond_ok = !n_f;
            4'b0110: cond_ok = v_f;
            4'b0111: cond_ok = !v_f;
            4'b1000: cond_ok = c_f && !z_f;
            4'b1001: cond_ok = !c_f || z_f;
            4'b1010: cond_ok = (n_f == v_f);
            4'b1011: cond_ok = (n_f != v_f);
            4'b1100: cond_ok = !z_f && (n_f == v_f);
            4'b1101: cond_ok = z_f || (n_f != v_f);
            4'b1110: cond_ok = 1'b1;
            default: cond_ok = 1'b0;
        endcase
    end
`else
    logic unused_bits;

    assign cond_ok     = 1'b1;
    assign unused_bits = ^{flags_nzcv, instr[31:28], instr[22:21]};
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_FETCH;
            pc    <= RESET_PC;
            instr <= '0;
            fault <= 1'b0;
            cnt   <= '0;
        end else begin
            state <= state_d;
            pc    <= pc_d;
            instr <= instr_d;
            fault <= fault_d;
            cnt   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state;
        pc_d    = pc;
        instr_d = instr;
        fault_d = fault;
        cnt_d   = '0;
        unique case (state)
            S_FETCH: begin
                if (timeout) begin
                    fault_d = 1'b1;
                    pc_d    = pc + 32'd4;
                end else if (mem.imem_ack) begin
                    instr_d = mem.imem_rdata;
                    state_d = S_DECODE;
                end else begin
                    cnt_d = cnt + 1'b1;
                end
            end
            S_DECODE: begin
                state_d = S_EXECUTE;
            end
            S_EXECUTE: begin
                state_d = S_FETCH;
                pc_d    = pc + 32'd4;
                if (cond_ok) begin
                    unique case (1'b1)
                        is_dp: begin
                            state_d = S_WRITEBACK;
                            pc_d    = pc;
                        end
                        is_ls: begin
                            state_d = S_MEMORY;
                            pc_d    = pc;
                        end
                        is_br: pc_d = pc + 32'd8 + br_off;
                        default: ;
                    endcase
                end
            end
            S_MEMORY: begin
                if (timeout) begin
                    fault_d = 1'b1;
                    pc_d    = pc + 32'd4;
                    state_d = S_FETCH;
                end else if (mem.dmem_ack) begin
                    state_d = is_load ? S_WRITEBACK : S_FETCH;
                    pc_d    = is_load ? pc : pc + 32'd4;
                end else begin
                    cnt_d = cnt + 1'b1;
                end
            end
            S_WRITEBACK: begin
                pc_d    = pc + 32'd4;
                state_d = S_FETCH;
            end
            default: state_d = S_FETCH;
        endcase
    end

    always_comb begin
        mem.imem_req   = 1'b0;
        mem.dmem_read  = 1'b0;
        mem.dmem_write = 1'b0;
        dec_enable     = 1'b0;
        alu_enable     = 1'b0;
        rf_we          = 1'b0;
        unique case (state)
            S_FETCH:     mem.imem_req = !timeout && !rst;
            S_DECODE:    dec_enable   = 1'b1;
            S_EXECUTE:   alu_enable   = cond_ok && is_dp;
            S_MEMORY: begin
                mem.dmem_read  = !timeout && is_load;
                mem.dmem_write = !timeout && !is_load;
            end
            S_WRITEBACK: rf_we = !(is_dp && is_cmp);
            default: ;
        endcase
    end

    assign mem.imem_addr = pc;
    assign busy          = (state != S_FETCH);

endmodule

// File: tb/tb_cpu_control_fsm.sv
// Directed and random instruction runs of cpu_control_fsm checked
// against a per-instruction transaction model.
module tb_cpu_control_fsm;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] instr, pc;
    logic        dec_enable, alu_enable, rf_we, fault, busy;
    logic [3:0]  flags_nzcv = 4'b0000;

    cpu_control_fsm_if bus ();

    cpu_control_fsm dut (
        .clk        (clk),
        .rst        (rst),
        .mem        (bus),
        .instr      (instr),
        .dec_enable (dec_enable),
        .alu_enable (alu_enable),
        .flags_nzcv (flags_nzcv),
        .rf_we      (rf_we),
        .pc         (pc),
        .fault      (fault),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int          errors = 0;
    int          checks = 0;
    logic [31:0] exp_pc = 32'h0;
    logic        exp_fault = 1'b0;

    typedef struct {
        int          cycles;
        logic [31:0] pc;
        int          dec, alu, rf, rd, wr;
        bit          flt;
    } res_t;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit cond_pass(input logic [3:0] c, input logic [3:0] f);
`ifdef COND_EXEC_EN
        bit n, z, cf, v, r;
        {n, z, cf, v} = f;
        case (c[3:1])
            3'd0: r = z;
            3'd1: r = cf;
            3'd2: r = n;
            3'd3: r = v;
            3'd4: r = cf && !z;
            3'd5: r = (n == v);
            3'd6: r = !z && (n == v);
            default: r = 1'b1;
        endcase
        if (c == 4'b1111) return 1'b0;
        if (c == 4'b1110) return 1'b1;
        return c[0] ? !r : r;
`else
        return 1'b1 | ^{c, f};
`endif
    endfunction

    // Expected outcome of one whole instruction from fetch to next fetch.
    function automatic res_t model(input logic [31:0] w, input logic [3:0] f,
                                   input logic [31:0] pcv, input int fd, input int dd);
        res_t        r;
        int          cls, n;
        logic [31:0] sx;
        r = '{cycles: 0, pc: pcv, dec: 0, alu: 0, rf: 0, rd: 0, wr: 0, flt: 1'b0};
        if (fd >= 255) begin
            r.cycles = 256;
            r.pc     = pcv + 32'd4;
            r.flt    = 1'b1;
            return r;
        end
        cls      = int'(w[27:25]);
        r.dec    = 1;
        r.cycles = fd + 3;
        if (!cond_pass(w[31:28], f)) begin
            r.pc = pcv + 32'd4;
        end else if (cls <= 1) begin
            r.alu    = 1;
            r.cycles = r.cycles + 1;
            r.rf     = (w[24:23] == 2'b10) ? 0 : 1;
            r.pc     = pcv + 32'd4;
        end else if (cls == 2 || cls == 3) begin
            if (dd >= 255) begin
                r.cycles = r.cycles + 256;
                r.flt    = 1'b1;
                n        = 255;
            end else begin
                r.cycles = r.cycles + dd + 1;
                n        = dd + 1;
            end
            if (w[20]) r.rd = n;
            else       r.wr = n;
            if (w[20] && dd < 255) begin
                r.cycles = r.cycles + 1;
                r.rf     = 1;
            end
            r.pc = pcv + 32'd4;
        end else if (cls == 5) begin
            sx   = {{8{w[23]}}, w[23:0]};
            r.pc = pcv + 32'd8 + sx * 32'd4;
        end else begin
            r.pc = pcv + 32'd4;
        end
        return r;
    endfunction

    // Called and returns at negedge+1 of a FETCH cycle with no ack yet driven.
    task automatic run(input logic [31:0] w, input int fd, input int dd, input string tag);
        res_t e, o;
        int   fw = 0, dw = 0, k = 0;
        bit   past = 1'b0, last = 1'b0;
        e = model(w, flags_nzcv, exp_pc, fd, dd);
        o = '{cycles: 0, pc: 32'h0, dec: 0, alu: 0, rf: 0, rd: 0, wr: 0, flt: 1'b0};
        bus.imem_rdata = w;
        forever begin
            if (k++ > 1000) begin
                check({tag, "_bound"}, 32'(k), 32'd1000);
                break;
            end
            if (past && !busy) break;
            o.cycles++;
            o.dec += int'(dec_enable);
            o.alu += int'(alu_enable);
            o.rf  += int'(rf_we);
            o.rd  += int'(bus.dmem_read);
            o.wr  += int'(bus.dmem_write);
            if (!busy) begin
                bus.dmem_ack = 1'($urandom_range(0, 1));
                if (!bus.imem_req) begin
                    bus.imem_ack = 1'($urandom_range(0, 1));
                    last = 1'b1;
                end else begin
                    bus.imem_ack = (fw == fd);
                    if (fw == fd) past = 1'b1;
                    fw++;
                end
            end else begin
                past = 1'b1;
                bus.imem_ack = 1'($urandom_range(0, 1));
                if (bus.dmem_read || bus.dmem_write) begin
                    bus.dmem_ack = (dw == dd);
                    dw++;
                end else begin
                    bus.dmem_ack = 1'($urandom_range(0, 1));
                end
            end
            @(negedge clk);
            #1;
            if (last) break;
        end
        bus.imem_ack = 1'b0;
        bus.dmem_ack = 1'b0;
        exp_pc    = e.pc;
        exp_fault = exp_fault | e.flt;
        check({tag, "_cycles"}, 32'(o.cycles), 32'(e.cycles));
        check({tag, "_pc"}, pc, exp_pc);
        check({tag, "_addr"}, bus.imem_addr, exp_pc);
        check({tag, "_dec"}, 32'(o.dec), 32'(e.dec));
        check({tag, "_alu"}, 32'(o.alu), 32'(e.alu));
        check({tag, "_rf"}, 32'(o.rf), 32'(e.rf));
        check({tag, "_rd"}, 32'(o.rd), 32'(e.rd));
        check({tag, "_wr"}, 32'(o.wr), 32'(e.wr));
        check({tag, "_fault"}, 32'(fault), 32'(exp_fault));
        if (fd < 255) check({tag, "_instr"}, instr, w);
    endtask

    function automatic logic [31:0] br_to(input logic [31:0] from, input logic [31:0] target);
        logic [31:0] d;
        d = target - from - 32'd8;
        return {8'hEA, d[25:2]};
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] w;
        int          cls_tab [6];
        cls_tab = '{0, 1, 2, 3, 5, 6};
        bus.imem_ack   = 1'b0;
        bus.dmem_ack   = 1'b0;
        bus.imem_rdata = 32'h0;

        @(negedge clk);
        #1;
        check("rst_pc", pc, 32'h0);
        check("rst_instr", instr, 32'h0);
        check("rst_fault", 32'(fault), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_ireq", 32'(bus.imem_req), 32'd0);
        check("rst_strobes", 32'({bus.dmem_read, bus.dmem_write, dec_enable, alu_enable, rf_we}), 32'd0);
        rst = 1'b0;
        #1;
        check("post_rst_ireq", 32'(bus.imem_req), 32'd1);

        run(32'hE080_2001, 0, 0, "add");
        run(32'hE591_0000, 0, 3, "ldr");
        run(32'hE581_0000, 1, 2, "str");
        run(32'hE151_0000, 0, 0, "cmp");
        run(br_to(exp_pc, 32'h100), 0, 0, "b_100");
        run(32'hEAFF_FFFE, 0, 0, "b_self");
        run(br_to(exp_pc, 32'hFFFF_FFFC), 2, 0, "b_top");
        run(32'hEC00_0000, 0, 0, "nop_wrap");
        check("wrap_pc", pc, 32'h0);

        flags_nzcv = 4'b0000;
        run(32'h0A00_0004, 0, 0, "beq_z0");
        flags_nzcv = 4'b0100;
        run(32'h0A00_0004, 0, 0, "beq_z1");
        flags_nzcv = 4'b0000;
        run(32'h0151_0000, 0, 0, "cmpeq_z0");

        run(32'hE080_2001, 255, 0, "ftimeout");
        run(32'hE080_2001, 1, 0, "after_ft");
        run(32'hE581_0000, 0, 255, "dtimeout");
        run(32'hE591_0000, 0, 254, "ldr_late");

        for (int i = 0; i < 40; i++) begin
            w = $urandom;
            w[27:25] = 3'(cls_tab[$urandom_range(0, 5)]);
            flags_nzcv = 4'($urandom);
            run(w, $urandom_range(0, 3), $urandom_range(0, 3), $sformatf("rnd%0d", i));
        end

        bus.imem_rdata = 32'hE581_0000;
        for (int k = 0; k < 20 && !bus.dmem_write; k++) begin
            bus.imem_ack = !busy;
            bus.dmem_ack = 1'b0;
            @(negedge clk);
            #1;
        end
        bus.imem_ack = 1'b0;
        check("mid_wr_before", 32'(bus.dmem_write), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check("mid_wr_drop", 32'(bus.dmem_write), 32'd0);
        check("mid_ireq", 32'(bus.imem_req), 32'd0);
        check("mid_pc", pc, 32'h0);
        check("mid_busy", 32'(busy), 32'd0);
        check("mid_fault", 32'(fault), 32'd0);
        @(negedge clk);
        #1;
        rst = 1'b0;
        #1;
        exp_pc    = 32'h0;
        exp_fault = 1'b0;
        run(32'hE080_2001, 0, 0, "add_after_rst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
